trace_bp_mc: RTL

- Multi-channel trace backpressure block. Merges num_channels_p trace sample streams into one valid/ready packet stream toward the trace FIFO.
- Trace sources cannot stall. When a sample cannot be buffered, the block counts it as a drop per channel and later emits a drop-record packet carrying the count.
- Sits between the per-unit trace samplers and the shared trace FIFO.
- Improvements over the single-channel block:
  - N channels with round-robin merge.
  - Proper stall-safe output register.
  - Ordered drop records.
  - Saturating counters with a sticky overflow flag.

---
 rtl/trace_pkg.sv | 24 ++
 rtl/trace_rr_arbiter.sv | 60 ++++++
 rtl/trace_bp_mc.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types and packet-layout helpers for the multi-channel trace
// backpressure block.
package trace_pkg;

   typedef enum logic {
      PKT_SAMPLE = 1'b0,
      PKT_DROP   = 1'b1
   } pkt_type_e;

   localparam int unsigned PKT_PAYLOAD_LSB = 0;

   function automatic int unsigned pkt_width(input int unsigned n, input int unsigned w);
      return 1 + $clog2(n) + w;
   endfunction

   function automatic int unsigned pkt_chan_lsb(input int unsigned w);
      return w;
   endfunction

   function automatic int unsigned pkt_type_bit(input int unsigned n, input int unsigned w);
      return w + $clog2(n);
   endfunction

endpackage

// File: rtl/trace_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a rotating
// pointer, which moves past the winner whenever advance_i is set.
module trace_rr_arbiter #(
   parameter  int unsigned width_p      = 4,
   localparam int unsigned idx_width_lp = $clog2(width_p)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [width_p-1:0]      req_i,
   input  logic                    advance_i,
   output logic [width_p-1:0]      gnt_oh_o,
   output logic [idx_width_lp-1:0] gnt_idx_o
);

   logic [idx_width_lp-1:0] ptr_q, ptr_d;
   logic [idx_width_lp-1:0] cand_idx_s;
   logic                    found_s;

   // first requester at or after the pointer wins
   always_comb begin
      gnt_oh_o   = '0;
      gnt_idx_o  = '0;
      found_s    = 1'b0;
      cand_idx_s = '0;
      for (int unsigned k = 0; k < width_p; k++) begin
         cand_idx_s = idx_width_lp'((32'(ptr_q) + k) % width_p);
         if (!found_s && req_i[cand_idx_s]) begin
            found_s              = 1'b1;
            gnt_oh_o[cand_idx_s] = 1'b1;
            gnt_idx_o            = cand_idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // pointer moves to winner+1, wrapping at width_p
   always_comb begin
      ptr_d = ptr_q;
      if (advance_i && found_s) begin
         if (gnt_idx_o == idx_width_lp'(width_p - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = gnt_idx_o + idx_width_lp'(1);
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // pointer register
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/trace_bp_mc.sv
// Multi-channel trace backpressure: merges non-stallable sample streams into
// one valid/ready packet stream, replacing lost samples with drop records.
module trace_bp_mc
   import trace_pkg::*;
#(
   parameter  int unsigned num_channels_p   = 4,
   parameter  int unsigned sample_width_p   = 16,
   parameter  int unsigned counter_width_p  = 16,
   localparam int unsigned chan_id_width_lp = $clog2(num_channels_p),
   localparam int unsigned pkt_width_lp     = pkt_width(num_channels_p, sample_width_p)
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [num_channels_p-1:0]                     chan_en_i,
   input  logic [num_channels_p-1:0]                     sample_valid_i,
   input  logic [num_channels_p-1:0][sample_width_p-1:0] sample_data_i,
   output logic                                          out_valid_o,
   output logic [pkt_width_lp-1:0]                       out_data_o,
   input  logic                                          out_ready_i,
   output logic [num_channels_p-1:0]                     overflow_o
);

   localparam int unsigned type_bit_lp = pkt_type_bit(num_channels_p, sample_width_p);
   localparam int unsigned chan_lsb_lp = pkt_chan_lsb(sample_width_p);

   if (counter_width_p > sample_width_p) begin : g_bad_cfg
      $error("trace_bp_mc: counter_width_p must not exceed sample_width_p");
   end

   logic                                        can_load_s;
   logic                                        any_gnt_s;
   logic [num_channels_p-1:0]                   in_s;
   logic [num_channels_p-1:0]                   slot_v_s;
   logic [num_channels_p-1:0]                   ctr_nz_s;
   logic [num_channels_p-1:0]                   req_s;
   logic [num_channels_p-1:0]                   gnt_oh_s;
   logic [chan_id_width_lp-1:0]                 gnt_idx_s;
   logic [num_channels_p-1:0][pkt_width_lp-1:0] cand_pkt_s;
   logic                                        out_valid_q, out_valid_d;
   logic [pkt_width_lp-1:0]                     out_data_q, out_data_d;

   assign can_load_s = ~out_valid_q | out_ready_i;
   assign in_s       = sample_valid_i & chan_en_i;
   // an incoming sample competes directly only when its channel has nothing older
   assign req_s      = {num_channels_p{can_load_s}} & (slot_v_s | ctr_nz_s | in_s);
   assign any_gnt_s  = |gnt_oh_s;

   for (genvar i = 0; i < num_channels_p; i++) begin : g_chan
      logic                       slot_v_q, slot_v_d;
      logic [sample_width_p-1:0]  slot_data_q, slot_data_d;
      logic [counter_width_p-1:0] ctr_q, ctr_d;
      logic                       ovf_q, ovf_d;
      logic                       slot_gnt_s, drop_gnt_s, byp_gnt_s, accept_s;
      pkt_type_e                  cand_type_s;
      logic [sample_width_p-1:0]  cand_payload_s;
      logic [pkt_width_lp-1:0]    cand_pkt_l;

      assign ctr_nz_s[i]   = |ctr_q;
      assign slot_v_s[i]   = slot_v_q;
      assign overflow_o[i] = ovf_q;
      assign cand_pkt_s[i] = cand_pkt_l;
      assign slot_gnt_s    = gnt_oh_s[i] & slot_v_q;
      assign drop_gnt_s    = gnt_oh_s[i] & ~slot_v_q & ctr_nz_s[i];
      assign byp_gnt_s     = gnt_oh_s[i] & ~slot_v_q & ~ctr_nz_s[i];
      assign accept_s      = (~ctr_nz_s[i] & (~slot_v_q | slot_gnt_s)) | drop_gnt_s;

      // candidate order: buffered sample, then drop record, then live sample
      always_comb begin
         cand_type_s    = PKT_SAMPLE;
         cand_payload_s = sample_data_i[i];
         if (slot_v_q) begin
            cand_payload_s = slot_data_q;
         end else if (ctr_nz_s[i]) begin
            cand_type_s    = PKT_DROP;
            cand_payload_s = sample_width_p'(ctr_q);
         end else begin
            cand_payload_s = sample_data_i[i];
         end
         cand_pkt_l                                        = '0;
         cand_pkt_l[type_bit_lp]                           = cand_type_s;
         cand_pkt_l[chan_lsb_lp +: chan_id_width_lp]       = chan_id_width_lp'(i);
         cand_pkt_l[PKT_PAYLOAD_LSB +: sample_width_p]     = cand_payload_s;
      end

      // slot / drop-counter next state
      always_comb begin
         slot_v_d    = slot_v_q;
         slot_data_d = slot_data_q;
         ctr_d       = ctr_q;
         ovf_d       = ovf_q;
         if (slot_gnt_s) begin
            slot_v_d = 1'b0;
         end else begin
            slot_v_d = slot_v_q;
         end
         if (drop_gnt_s) begin
            ctr_d = '0;
         end else begin
            ctr_d = ctr_q;
         end
         if (in_s[i]) begin
            if (byp_gnt_s) begin
               slot_v_d = 1'b0;
            end else if (accept_s) begin
               slot_v_d    = 1'b1;
               slot_data_d = sample_data_i[i];
            end else if (&ctr_q) begin
               ovf_d = 1'b1;
            end else begin
               ctr_d = ctr_q + counter_width_p'(1);
            end
         end else begin
            ovf_d = ovf_q;
         end
      end

      // per-channel state registers
      always_ff @(posedge clk) begin
         if (rst) begin
            slot_v_q    <= 1'b0;
            slot_data_q <= '0;
            ctr_q       <= '0;
            ovf_q       <= 1'b0;
         end else begin
            slot_v_q    <= slot_v_d;
            slot_data_q <= slot_data_d;
            ctr_q       <= ctr_d;
            ovf_q       <= ovf_d;
         end
      end
   end

   trace_rr_arbiter #(
      .width_p   (num_channels_p)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_s),
      .advance_i (can_load_s),
      .gnt_oh_o  (gnt_oh_s),
      .gnt_idx_o (gnt_idx_s)
   );

   // output register only changes when empty or handshaking
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (can_load_s) begin
         out_valid_d = any_gnt_s;
         if (any_gnt_s) begin
            out_data_d = cand_pkt_s[gnt_idx_s];
         end else begin
            out_data_d = out_data_q;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // output register
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule
